// File: rtl/xrbus_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : xrbus_rx_pkg
//  Purpose  : Shared types and constants for the XR-BUS device-side receive
//             deframer. It holds the state and error-code enums, the magic and
//             broadcast constants, and the bit offsets of the W0/W2 fields.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package xrbus_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR1    = 3'd1,
    ST_HDR2    = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CHECK   = 3'd4,
    ST_DRAIN   = 3'd5,
    ST_DROP    = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_MAGIC    = 3'd1,
    ERR_VERSION  = 3'd2,
    ERR_LENGTH   = 3'd3,
    ERR_BOUNDARY = 3'd4,
    ERR_CHECKSUM = 3'd5,
    ERR_FRAMING  = 3'd6,
    ERR_TIMEOUT  = 3'd7
  } err_e;

  localparam logic [15:0] XRBUS_MAGIC        = 16'hA55A;
  localparam logic [15:0] BROADCAST_BOUNDARY = 16'hFFFF;

  // W0 = {magic, version, op_code, module_id, boundary_id}
  localparam int W0_MAGIC_LSB    = 48;
  localparam int W0_VERSION_LSB  = 40;
  localparam int W0_OPCODE_LSB   = 32;
  localparam int W0_MODULE_LSB   = 16;
  localparam int W0_BOUNDARY_LSB = 0;

  // W2 = {payload_len, dst_boundary, semantic_hash}
  localparam int W2_LEN_LSB  = 48;
  localparam int W2_DST_LSB  = 32;
  localparam int W2_HASH_LSB = 0;

endpackage
`default_nettype wire

// File: rtl/xrbus_rx_payload_buf.sv
`default_nettype none
// ============================================================================
//  Module   : xrbus_rx_payload_buf
//  Purpose  : Payload store for one frame. Words are written in arrival order
//             and later presented in the same order on a valid/ready stream.
//  Ports    : device_clk, rst_n      clock, async active-low reset
//             clr                    zero both pointers (frame start / idle)
//             wr_en, wr_data         write one payload word
//             wr_count               words written so far this frame
//             rd_en                  read side enabled (deframer draining)
//             n_words                number of words in this frame
//             out_ready              downstream accepts word
//             out_data/valid/last    read-side stream
//  Revision : 1.0  initial release
// ============================================================================
module xrbus_rx_payload_buf #(
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH) + 1
) (
  input  logic             device_clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [63:0]      wr_data,
  output logic [PTR_W-1:0] wr_count,
  input  logic             rd_en,
  input  logic [PTR_W-1:0] n_words,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic             out_valid,
  output logic             out_last
);

  localparam int AW = $clog2(DEPTH);

  logic [63:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             wr_ok;

  // Writes beyond DEPTH cannot happen for a legal length; guard anyway.
  assign wr_ok = wr_en && !clr && (wr_ptr_q < PTR_W'(DEPTH));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (out_valid && out_ready) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge device_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; its contents are meaningless until written.
  always_ff @(posedge device_clk) begin
    if (wr_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  assign wr_count  = wr_ptr_q;
  assign out_valid = rd_en && (rd_ptr_q < n_words);
  assign out_last  = out_valid && (rd_ptr_q == n_words - PTR_W'(1));
  // Masked so the stream reads zero whenever nothing is being offered.
  assign out_data  = out_valid ? mem_q[rd_ptr_q[AW-1:0]] : 64'd0;

endmodule
`default_nettype wire

// File: rtl/xrbus_rx_deframer.sv
`default_nettype none
// ============================================================================
//  Module   : xrbus_rx_deframer
//  Purpose  : XR-BUS device-side receiver. Parses and checks the 3-word
//             header, buffers the payload, verifies the XOR trailer, then
//             releases the header fields and payload. Bad frames are dropped,
//             counted and reported through err_pulse/err_code.
//  Ports    : device_clk, rst_n            clock, async active-low reset
//             local_boundary               this node's boundary id
//             in_data/in_valid/in_last     frame word stream, in_ready back
//             out_hdr_valid, out_*         header fields (valid in DRAIN)
//             out_data/valid/last/ready    payload word stream
//             err_pulse, err_code          error strobe and latest code
//             frames_ok, frames_dropped    saturating frame counters
//  Options  : XRBUS_RX_TIMEOUT_EN enables the idle-gap watchdog (error 7).
//  Revision : 1.0  initial release
// ============================================================================
module xrbus_rx_deframer
  import xrbus_rx_pkg::*;
#(
  parameter logic [15:0] MAGIC             = XRBUS_MAGIC,
  parameter logic [7:0]  MIN_VERSION       = 8'd1,
  parameter logic [7:0]  MAX_VERSION       = 8'd2,
  parameter int          MAX_PAYLOAD_BYTES = 128,
  parameter int          TIMEOUT_CYC       = 256
) (
  input  logic        device_clk,
  input  logic        rst_n,
  input  logic [15:0] local_boundary,
  input  logic [63:0] in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic        out_hdr_valid,
  output logic [15:0] out_module_id,
  output logic [15:0] out_boundary_id,
  output logic [7:0]  out_op_code,
  output logic [7:0]  out_version,
  output logic [63:0] out_device_time,
  output logic [31:0] out_semantic_hash,
  output logic [9:0]  out_payload_len,
  output logic [63:0] out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic        err_pulse,
  output logic [2:0]  err_code,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_dropped
);

  localparam int DEPTH = (MAX_PAYLOAD_BYTES + 7) / 8;
  localparam int PTR_W = $clog2(DEPTH) + 1;

  state_e           state_q, state_d;
  logic [63:0]      csum_q, csum_d;
  logic [15:0]      module_id_q, module_id_d;
  logic [15:0]      boundary_id_q, boundary_id_d;
  logic [7:0]       op_code_q, op_code_d;
  logic [7:0]       version_q, version_d;
  logic [63:0]      device_time_q, device_time_d;
  logic [31:0]      semantic_hash_q, semantic_hash_d;
  logic [9:0]       payload_len_q, payload_len_d;
  logic [PTR_W-1:0] n_words_q, n_words_d;
  logic             err_pulse_q, err_pulse_d;
  err_e             err_code_q, err_code_d;
  logic [15:0]      frames_ok_q, frames_ok_d;
  logic [15:0]      frames_dropped_q, frames_dropped_d;

  logic             accept;
  logic             err_fire;
  err_e             err_sel;
  logic             ok_fire;
  logic             buf_wr;
  logic             timeout_hit;
  logic [PTR_W-1:0] wr_count;

  logic [15:0]      w_magic;
  logic [7:0]       w_version;
  logic [15:0]      w_len;
  logic [15:0]      w_dst;

  assign in_ready  = (state_q != ST_DRAIN);
  assign accept    = in_valid && in_ready;
  assign w_magic   = in_data[W0_MAGIC_LSB +: 16];
  assign w_version = in_data[W0_VERSION_LSB +: 8];
  assign w_len     = in_data[W2_LEN_LSB +: 16];
  assign w_dst     = in_data[W2_DST_LSB +: 16];

  // --------------------------------------------------------------------------
  // Idle-gap watchdog
  // --------------------------------------------------------------------------
`ifdef XRBUS_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;
  logic            waiting;

  assign waiting = (state_q == ST_HDR1) || (state_q == ST_HDR2) ||
                   (state_q == ST_PAYLOAD) || (state_q == ST_CHECK);

  // Any accepted word (or leaving the mid-frame states) restarts the count.
  always_comb begin
    idle_cnt_d  = '0;
    timeout_hit = 1'b0;
    if (waiting && !in_valid) begin
      if (idle_cnt_q == TO_W'(TIMEOUT_CYC - 1)) timeout_hit = 1'b1;
      else idle_cnt_d = idle_cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge device_clk or negedge rst_n) begin
    if (!rst_n) idle_cnt_q <= '0;
    else        idle_cnt_q <= idle_cnt_d;
  end
`else
  logic [31:0] timeout_cyc_unused;
  assign timeout_cyc_unused = 32'(TIMEOUT_CYC);
  assign timeout_hit        = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Next-state / datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_d         = state_q;
    csum_d          = csum_q;
    module_id_d     = module_id_q;
    boundary_id_d   = boundary_id_q;
    op_code_d       = op_code_q;
    version_d       = version_q;
    device_time_d   = device_time_q;
    semantic_hash_d = semantic_hash_q;
    payload_len_d   = payload_len_q;
    n_words_d       = n_words_q;
    err_fire        = 1'b0;
    err_sel         = ERR_NONE;
    ok_fire         = 1'b0;
    buf_wr          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        csum_d = '0;
        if (accept) begin
          csum_d        = in_data;
          module_id_d   = in_data[W0_MODULE_LSB +: 16];
          boundary_id_d = in_data[W0_BOUNDARY_LSB +: 16];
          op_code_d     = in_data[W0_OPCODE_LSB +: 8];
          version_d     = w_version;
          // Content errors take priority over a premature in_last.
          if (w_magic != MAGIC) begin
            err_fire = 1'b1;
            err_sel  = ERR_MAGIC;
            state_d  = in_last ? ST_IDLE : ST_DROP;
          end else if (w_version < MIN_VERSION || w_version > MAX_VERSION) begin
            err_fire = 1'b1;
            err_sel  = ERR_VERSION;
            state_d  = in_last ? ST_IDLE : ST_DROP;
          end else if (in_last) begin
            err_fire = 1'b1;
            err_sel  = ERR_FRAMING;
            state_d  = ST_IDLE;
          end else begin
            state_d = ST_HDR1;
          end
        end
      end

      ST_HDR1: begin
        if (accept) begin
          csum_d        = csum_q ^ in_data;
          device_time_d = in_data;
          if (in_last) begin
            err_fire = 1'b1;
            err_sel  = ERR_FRAMING;
            state_d  = ST_IDLE;
          end else begin
            state_d = ST_HDR2;
          end
        end
      end

      ST_HDR2: begin
        if (accept) begin
          csum_d          = csum_q ^ in_data;
          semantic_hash_d = in_data[W2_HASH_LSB +: 32];
          payload_len_d   = w_len[9:0];
          n_words_d       = PTR_W'((32'(w_len) + 32'd7) >> 3);
          if (w_len > 16'(MAX_PAYLOAD_BYTES)) begin
            err_fire = 1'b1;
            err_sel  = ERR_LENGTH;
            state_d  = in_last ? ST_IDLE : ST_DROP;
          end else if (w_dst != local_boundary && w_dst != BROADCAST_BOUNDARY) begin
            err_fire = 1'b1;
            err_sel  = ERR_BOUNDARY;
            state_d  = in_last ? ST_IDLE : ST_DROP;
          end else if (in_last) begin
            err_fire = 1'b1;
            err_sel  = ERR_FRAMING;
            state_d  = ST_IDLE;
          end else begin
            state_d = (w_len == 16'd0) ? ST_CHECK : ST_PAYLOAD;
          end
        end
      end

      ST_PAYLOAD: begin
        if (accept) begin
          csum_d = csum_q ^ in_data;
          buf_wr = 1'b1;
          if (in_last) begin
            err_fire = 1'b1;
            err_sel  = ERR_FRAMING;
            state_d  = ST_IDLE;
          end else if (wr_count + PTR_W'(1) == n_words_q) begin
            state_d = ST_CHECK;
          end
        end
      end

      ST_CHECK: begin
        if (accept) begin
          if (in_data != csum_q) begin
            err_fire = 1'b1;
            err_sel  = ERR_CHECKSUM;
            state_d  = in_last ? ST_IDLE : ST_DROP;
          end else if (!in_last) begin
            // Trailer matched but the frame keeps going: discard the rest.
            err_fire = 1'b1;
            err_sel  = ERR_FRAMING;
            state_d  = ST_DROP;
          end else begin
            ok_fire = 1'b1;
            state_d = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        if (n_words_q == '0) state_d = ST_IDLE;
        else if (out_valid && out_ready && out_last) state_d = ST_IDLE;
      end

      ST_DROP: begin
        if (accept && in_last) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // Only fires with in_valid low, so no word is being taken this cycle.
    if (timeout_hit) begin
      err_fire = 1'b1;
      err_sel  = ERR_TIMEOUT;
      state_d  = ST_IDLE;
    end
  end

  always_comb begin
    err_pulse_d      = err_fire;
    err_code_d       = err_fire ? err_sel : err_code_q;
    frames_ok_d      = frames_ok_q;
    frames_dropped_d = frames_dropped_q;
    if (ok_fire && frames_ok_q != 16'hFFFF)
      frames_ok_d = frames_ok_q + 16'd1;
    if (err_fire && frames_dropped_q != 16'hFFFF)
      frames_dropped_d = frames_dropped_q + 16'd1;
  end

  always_ff @(posedge device_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      csum_q           <= '0;
      module_id_q      <= '0;
      boundary_id_q    <= '0;
      op_code_q        <= '0;
      version_q        <= '0;
      device_time_q    <= '0;
      semantic_hash_q  <= '0;
      payload_len_q    <= '0;
      n_words_q        <= '0;
      err_pulse_q      <= 1'b0;
      err_code_q       <= ERR_NONE;
      frames_ok_q      <= '0;
      frames_dropped_q <= '0;
    end else begin
      state_q          <= state_d;
      csum_q           <= csum_d;
      module_id_q      <= module_id_d;
      boundary_id_q    <= boundary_id_d;
      op_code_q        <= op_code_d;
      version_q        <= version_d;
      device_time_q    <= device_time_d;
      semantic_hash_q  <= semantic_hash_d;
      payload_len_q    <= payload_len_d;
      n_words_q        <= n_words_d;
      err_pulse_q      <= err_pulse_d;
      err_code_q       <= err_code_d;
      frames_ok_q      <= frames_ok_d;
      frames_dropped_q <= frames_dropped_d;
    end
  end

  // --------------------------------------------------------------------------
  // Payload buffer (pointers held at zero while idle)
  // --------------------------------------------------------------------------
  xrbus_rx_payload_buf #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_payload_buf (
    .device_clk (device_clk),
    .rst_n      (rst_n),
    .clr        (state_q == ST_IDLE),
    .wr_en      (buf_wr),
    .wr_data    (in_data),
    .wr_count   (wr_count),
    .rd_en      (state_q == ST_DRAIN),
    .n_words    (n_words_q),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_last   (out_last)
  );

  assign out_hdr_valid     = (state_q == ST_DRAIN);
  assign out_module_id     = module_id_q;
  assign out_boundary_id   = boundary_id_q;
  assign out_op_code       = op_code_q;
  assign out_version       = version_q;
  assign out_device_time   = device_time_q;
  assign out_semantic_hash = semantic_hash_q;
  assign out_payload_len   = payload_len_q;
  assign err_pulse         = err_pulse_q;
  assign err_code          = err_code_q;
  assign frames_ok         = frames_ok_q;
  assign frames_dropped    = frames_dropped_q;

endmodule
`default_nettype wire

// File: tb/tb_xrbus_rx_deframer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_xrbus_rx_deframer
//  Purpose  : Directed self-checking bench for xrbus_rx_deframer: good frames,
//             checksum/magic/version/boundary/framing errors, back-pressure
//             during drain, zero-length frame and mid-frame reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_xrbus_rx_deframer;

  localparam logic [63:0] DEV_TIME = 64'h0123_4567_89AB_CDEF;
  localparam logic [15:0] GOOD_MAGIC = 16'hA55A;

  logic        device_clk = 1'b0;
  logic        rst_n      = 1'b0;
  logic [15:0] local_boundary;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic        out_hdr_valid;
  logic [15:0] out_module_id;
  logic [15:0] out_boundary_id;
  logic [7:0]  out_op_code;
  logic [7:0]  out_version;
  logic [63:0] out_device_time;
  logic [31:0] out_semantic_hash;
  logic [9:0]  out_payload_len;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;
  logic        err_pulse;
  logic [2:0]  err_code;
  logic [15:0] frames_ok;
  logic [15:0] frames_dropped;

  xrbus_rx_deframer dut (
    .device_clk        (device_clk),
    .rst_n             (rst_n),
    .local_boundary    (local_boundary),
    .in_data           (in_data),
    .in_valid          (in_valid),
    .in_last           (in_last),
    .in_ready          (in_ready),
    .out_hdr_valid     (out_hdr_valid),
    .out_module_id     (out_module_id),
    .out_boundary_id   (out_boundary_id),
    .out_op_code       (out_op_code),
    .out_version       (out_version),
    .out_device_time   (out_device_time),
    .out_semantic_hash (out_semantic_hash),
    .out_payload_len   (out_payload_len),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_last          (out_last),
    .out_ready         (out_ready),
    .err_pulse         (err_pulse),
    .err_code          (err_code),
    .frames_ok         (frames_ok),
    .frames_dropped    (frames_dropped)
  );

  always #5 device_clk = ~device_clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int words_accepted = 0;
  int valid_cycles   = 0;
  int err_cnt        = 0;
  logic [63:0] got_data[$];
  logic        got_last[$];
  logic [63:0] pay [16];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output-side observer, sampled on the falling edge.
  always @(negedge device_clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_last.push_back(out_last);
      end
      if (out_valid) valid_cycles++;
      if (err_pulse) err_cnt++;
    end
  end

  function automatic logic [63:0] data_at(input int i);
    if (i < got_data.size()) return got_data[i];
    return 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  function automatic logic last_at(input int i);
    if (i < got_last.size()) return got_last[i];
    return 1'bx;
  endfunction

  task automatic sync();
    @(posedge device_clk);
    #2;
  endtask

  task automatic clear_obs();
    got_data.delete();
    got_last.delete();
  endtask

  // Present one word and hold it until it transfers (bounded).
  task automatic send_word(input logic [63:0] d, input logic last);
    bit done;
    done     = 1'b0;
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge device_clk);
      done = in_ready;
      @(posedge device_clk);
    end
    #2;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (done) words_accepted++;
    check_eq("in_ready_on_send", {63'd0, done}, 64'd1);
  endtask

  // last_pos < 0: in_last on the trailer; otherwise in_last on word last_pos
  // and the frame ends there.
  task automatic send_frame(input logic [15:0] magic, input logic [7:0] ver,
                            input logic [15:0] len, input logic [15:0] dst,
                            input int npay, input int last_pos,
                            input logic [63:0] flip);
    logic [63:0] w [20];
    logic [63:0] x;
    int          total;
    w[0] = {magic, ver, 8'h5C, 16'h1111, 16'h2222};
    w[1] = DEV_TIME;
    w[2] = {len, dst, 32'hDEADBEEF};
    for (int i = 0; i < npay; i++) w[3+i] = pay[i];
    x = 64'd0;
    for (int i = 0; i < 3 + npay; i++) x = x ^ w[i];
    w[3+npay] = x ^ flip;
    total = 4 + npay;
    if (last_pos >= 0) total = last_pos + 1;
    for (int i = 0; i < total; i++) send_word(w[i], (i == total - 1));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge device_clk);
    while (out_hdr_valid && n < 100) begin
      @(negedge device_clk);
      n++;
    end
    check_eq("drain_done", {63'd0, out_hdr_valid}, 64'd0);
    sync();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int wa0;
    local_boundary = 16'h0042;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    pay[0] = 64'hAAAA_0000_AAAA_0001;
    pay[1] = 64'hBBBB_0000_BBBB_0002;
    pay[2] = 64'hCCCC_0000_CCCC_0003;
    for (int i = 3; i < 16; i++) pay[i] = '0;

    repeat (3) @(posedge device_clk);
    #2 rst_n = 1'b1;

    // ---- reset state ----
    @(negedge device_clk);
    check_eq("rst_in_ready",   in_ready, 1);
    check_eq("rst_hdr_valid",  out_hdr_valid, 0);
    check_eq("rst_out_valid",  out_valid, 0);
    check_eq("rst_err_code",   err_code, 0);
    check_eq("rst_frames_ok",  frames_ok, 0);
    check_eq("rst_frames_drp", frames_dropped, 0);
    check_eq("rst_module_id",  out_module_id, 0);
    check_eq("rst_dev_time",   out_device_time, 0);
    sync();

    // ---- T1: good frame, len 20, three words ----
    clear_obs();
    send_frame(GOOD_MAGIC, 8'd2, 16'd20, 16'h0042, 3, -1, 64'd0);
    @(negedge device_clk);
    check_eq("t1_hdr_valid",  out_hdr_valid, 1);
    check_eq("t1_in_ready",   in_ready, 0);
    check_eq("t1_module_id",  out_module_id, 16'h1111);
    check_eq("t1_boundary",   out_boundary_id, 16'h2222);
    check_eq("t1_op_code",    out_op_code, 8'h5C);
    check_eq("t1_version",    out_version, 8'd2);
    check_eq("t1_dev_time",   out_device_time, DEV_TIME);
    check_eq("t1_hash",       out_semantic_hash, 32'hDEADBEEF);
    check_eq("t1_len",        out_payload_len, 10'd20);
    check_eq("t1_frames_ok",  frames_ok, 1);
    wait_idle();
    check_eq("t1_nwords", got_data.size(), 3);
    check_eq("t1_w0", data_at(0), 64'hAAAA_0000_AAAA_0001);
    check_eq("t1_w1", data_at(1), 64'hBBBB_0000_BBBB_0002);
    check_eq("t1_w2", data_at(2), 64'hCCCC_0000_CCCC_0003);
    check_eq("t1_last0", last_at(0), 0);
    check_eq("t1_last2", last_at(2), 1);

    // ---- T2: trailer bit 0 flipped ----
    clear_obs();
    send_frame(GOOD_MAGIC, 8'd2, 16'd20, 16'h0042, 3, -1, 64'd1);
    @(negedge device_clk);
    check_eq("t2_err_pulse", err_pulse, 1);
    check_eq("t2_err_code",  err_code, 5);
    check_eq("t2_dropped",   frames_dropped, 1);
    check_eq("t2_frames_ok", frames_ok, 1);
    repeat (4) @(negedge device_clk);
    #1;
    check_eq("t2_no_out_valid", valid_cycles, 3);
    check_eq("t2_err_cnt", err_cnt, 1);
    sync();

    // ---- T3: bad magic, 5 words dropped, good frame straight after ----
    clear_obs();
    wa0 = words_accepted;
    send_frame(16'h1234, 8'd2, 16'd16, 16'h0042, 1, -1, 64'd0);
    check_eq("t3_consumed", words_accepted - wa0, 5);
    send_frame(GOOD_MAGIC, 8'd2, 16'd20, 16'h0042, 3, -1, 64'd0);
    @(negedge device_clk);
    #1;
    check_eq("t3_err_code",  err_code, 1);
    check_eq("t3_dropped",   frames_dropped, 2);
    check_eq("t3_err_cnt",   err_cnt, 2);
    check_eq("t3_hdr_valid", out_hdr_valid, 1);
    check_eq("t3_frames_ok", frames_ok, 2);
    wait_idle();
    check_eq("t3_nwords", got_data.size(), 3);

    // ---- T4: len 16 with back-pressure during drain ----
    clear_obs();
    pay[0] = 64'h1111_2222_3333_4444;
    pay[1] = 64'h5555_6666_7777_8888;
    out_ready = 1'b0;
    send_frame(GOOD_MAGIC, 8'd1, 16'd16, 16'h0042, 2, -1, 64'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge device_clk);
      if (i == 0 || i == 9) begin
        check_eq("t4_in_ready",  in_ready, 0);
        check_eq("t4_out_valid", out_valid, 1);
        check_eq("t4_out_data",  out_data, 64'h1111_2222_3333_4444);
        check_eq("t4_out_last",  out_last, 0);
      end
    end
    sync();
    out_ready = 1'b1;
    wait_idle();
    check_eq("t4_nwords", got_data.size(), 2);
    check_eq("t4_w0", data_at(0), 64'h1111_2222_3333_4444);
    check_eq("t4_w1", data_at(1), 64'h5555_6666_7777_8888);
    check_eq("t4_last1", last_at(1), 1);
    check_eq("t4_frames_ok", frames_ok, 3);

    // ---- T5: version 3, broadcast len 0, wrong dst ----
    clear_obs();
    send_frame(GOOD_MAGIC, 8'd3, 16'd8, 16'h0042, 1, -1, 64'd0);
    @(negedge device_clk);
    check_eq("t5_ver_err_code", err_code, 2);
    check_eq("t5_ver_dropped",  frames_dropped, 3);
    sync();
    send_frame(GOOD_MAGIC, 8'd2, 16'd0, 16'hFFFF, 0, -1, 64'd0);
    @(negedge device_clk);
    check_eq("t5_len0_hdr_valid", out_hdr_valid, 1);
    check_eq("t5_len0_out_valid", out_valid, 0);
    check_eq("t5_len0_len",       out_payload_len, 0);
    check_eq("t5_len0_frames_ok", frames_ok, 4);
    @(negedge device_clk);
    check_eq("t5_len0_one_cycle", out_hdr_valid, 0);
    check_eq("t5_len0_in_ready",  in_ready, 1);
    sync();
    send_frame(GOOD_MAGIC, 8'd2, 16'd8, 16'h0007, 1, -1, 64'd0);
    @(negedge device_clk);
    check_eq("t5_dst_err_code", err_code, 4);
    check_eq("t5_dst_dropped",  frames_dropped, 4);
    check_eq("t5_got_none",     got_data.size(), 0);
    sync();

    // ---- T6: len 24 with in_last on payload word 2, then good frame ----
    pay[0] = 64'hAAAA_0000_AAAA_0001;
    pay[1] = 64'hBBBB_0000_BBBB_0002;
    pay[2] = 64'hCCCC_0000_CCCC_0003;
    send_frame(GOOD_MAGIC, 8'd2, 16'd24, 16'h0042, 3, 4, 64'd0);
    @(negedge device_clk);
    check_eq("t6_err_pulse", err_pulse, 1);
    check_eq("t6_err_code",  err_code, 6);
    check_eq("t6_dropped",   frames_dropped, 5);
    sync();
    clear_obs();
    send_frame(GOOD_MAGIC, 8'd2, 16'd20, 16'h0042, 3, -1, 64'd0);
    @(negedge device_clk);
    check_eq("t6_next_hdr_valid", out_hdr_valid, 1);
    check_eq("t6_next_frames_ok", frames_ok, 5);
    wait_idle();
    check_eq("t6_next_nwords", got_data.size(), 3);

    // ---- T7: reset in the middle of a frame ----
    send_word({GOOD_MAGIC, 8'd2, 8'h5C, 16'h1111, 16'h2222}, 1'b0);
    send_word(DEV_TIME, 1'b0);
    rst_n = 1'b0;
    @(negedge device_clk);
    check_eq("t7_frames_ok", frames_ok, 0);
    check_eq("t7_dropped",   frames_dropped, 0);
    check_eq("t7_err_code",  err_code, 0);
    check_eq("t7_module_id", out_module_id, 0);
    check_eq("t7_dev_time",  out_device_time, 0);
    check_eq("t7_hdr_valid", out_hdr_valid, 0);
    sync();
    rst_n = 1'b1;
    clear_obs();
    send_frame(GOOD_MAGIC, 8'd2, 16'd20, 16'h0042, 3, -1, 64'd0);
    @(negedge device_clk);
    check_eq("t7_after_frames_ok", frames_ok, 1);
    wait_idle();
    check_eq("t7_after_nwords", got_data.size(), 3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/xrbus_rx_deframer.md
Name: xrbus_rx_deframer

Overview:
Device-side receive end of XR-BUS. Accepts a serialized frame as a 64-bit word stream, parses and validates the header, buffers the payload until the trailer checksum is verified, then releases the header fields and payload words to the local module. Errored frames are dropped, and the drop is counted and reported.

Parameters:
MAGIC, 16'hA55A, required value of W0[63:48]
MIN_VERSION, 8'd1, lowest accepted protocol version
MAX_VERSION, 8'd2, highest accepted protocol version
MAX_PAYLOAD_BYTES, 128, largest legal payload_len; sets buffer depth (128/8 = 16 words)
TIMEOUT_CYC, 256, watchdog limit; used only with the optional feature

Ports:
device_clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
local_boundary  in  16  this node's boundary id
in_data  in  64  frame word
in_valid  in  1  in_data valid
in_last  in  1  final word of frame
in_ready  out  1  deframer accepts word
out_hdr_valid  out  1  header fields valid (level, DRAIN only)
out_module_id  out  16  source module id
out_boundary_id  out  16  source boundary id
out_op_code  out  8  op code
out_version  out  8  frame version
out_device_time  out  64  device timestamp
out_semantic_hash  out  32  semantic hash
out_payload_len  out  10  payload length in bytes
out_data  out  64  payload word
out_valid  out  1  payload word valid
out_last  out  1  last payload word
out_ready  in  1  downstream accepts word
err_pulse  out  1  one-cycle error strobe
err_code  out  3  code of latest error, held until next error
frames_ok  out  16  accepted frames, saturating
frames_dropped  out  16  dropped frames, saturating

Behaviour:
- Frame layout:
  - W0 = {magic[63:48], version[47:40], op_code[39:32], module_id[31:16], boundary_id[15:0]}
  - W1 = device_time
  - W2 = {payload_len[63:48], dst_boundary[47:32], semantic_hash[31:0]}
  - Payload: N = ceil(len/8) words
  - Trailer: XOR of W0 through the last payload word
- Handshake: a word transfers when in_valid & in_ready. A payload word transfers when out_valid & out_ready.
- States: IDLE, HDR1, HDR2, PAYLOAD, CHECK, DRAIN, DROP.
  - in_ready = 1 in every state except DRAIN.
- IDLE: accept W0.
  - magic != MAGIC -> error 1.
  - version outside [MIN_VERSION, MAX_VERSION] -> error 2.
  - Otherwise -> HDR1.
- HDR1: accept W1 -> HDR2.
- HDR2: accept W2.
  - payload_len > MAX_PAYLOAD_BYTES -> error 3.
  - dst_boundary not equal to local_boundary and not 16'hFFFF -> error 4.
  - Otherwise -> PAYLOAD, or CHECK if len = 0.
- PAYLOAD: each word is written to the buffer. After the Nth word -> CHECK.
- CHECK: accept trailer.
  - Mismatch -> error 5.
  - Otherwise -> DRAIN and frames_ok++.
- in_last rules:
  - in_last on any word before the trailer -> error 6, go to IDLE.
  - in_last = 0 on the trailer -> error 6, go to DROP.
- On errors 1–5: go to DROP, unless in_last accompanied the errored word, in which case go to IDLE.
  - frames_dropped++, err_pulse for 1 cycle, err_code updated.
- DROP: consume words until in_last, then go to IDLE.
- DRAIN:
  - Header outputs are held and out_hdr_valid = 1.
  - First out_valid appears the cycle after the trailer is accepted.
  - Words go out in order; out_last on word N.
  - out_data and out_valid stay stable while out_ready = 0.
  - Go to IDLE after the last word transfers.
  - len = 0: DRAIN lasts exactly one cycle, with out_valid = 0.
- Checksum arithmetic: 64-bit running XOR, cleared on entering IDLE. Words where len is not a multiple of 8 carry don't-care padding, which is still included in the XOR.
- Counters saturate at 16'hFFFF and never wrap.
- Reset, including mid-frame: state = IDLE and all outputs 0. This covers err_code, both counters, and every header field. Buffer contents are don't-care.

Optional Feature:
XRBUS_RX_TIMEOUT_EN
- When defined: an idle-gap counter runs in HDR1, HDR2, PAYLOAD and CHECK.
  - It resets on every accepted word.
  - After TIMEOUT_CYC consecutive cycles with in_valid = 0: error 7, frames_dropped++, go to IDLE.
- When undefined: no counter, no code 7, and the deframer waits indefinitely.

Decomposition:
- Package xrbus_rx_pkg:
  - state enum
  - error-code enum: 1 MAGIC, 2 VERSION, 3 LENGTH, 4 BOUNDARY, 5 CHECKSUM, 6 FRAMING, 7 TIMEOUT
  - MAGIC default
  - broadcast boundary 16'hFFFF
  - W0/W2 field bit offsets
- Sub-module xrbus_rx_payload_buf:
  - 16x64 storage with write and read pointers
  - read side presents out_data/out_valid/out_last
  - pointers cleared on frame start

Test Plan:
- Good frame: version 2, local_boundary = dst = 16'h0042, len 20, payload words A, B, C, correct XOR -> out_hdr_valid, fields match, three out words A, B, C with out_last on C, frames_ok = 1.
- Same frame with the trailer bit 0 flipped -> err_pulse, err_code = 5, out_valid never asserted, frames_dropped = 1, frames_ok unchanged.
- W0 magic 16'h1234 followed by 4 more words ending in in_last -> err_code = 1, all 5 words consumed, an immediately following good frame is accepted.
- Good frame len 16 with out_ready held low for 10 cycles during DRAIN -> in_ready = 0, out_data and out_valid stable, both words delivered after release.
- Three frames:
  - version 3 -> err_code = 2
  - dst 16'hFFFF with len 0 -> accepted, one-cycle DRAIN, no out_valid
  - dst 16'h0007 -> err_code = 4
- len 24 frame with in_last on payload word 2 -> err_code = 6, state IDLE, next W0 parsed normally.
